// File: rtl/cabin_cmd_pkg.sv
// ============================================================================
// Module   : cabin_cmd_pkg
// Brief    : Shared defaults and helpers for the cabin command conditioner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cabin_cmd_pkg;

  localparam int CABIN_NUM_CH   = 4;
  localparam int CABIN_DEBOUNCE = 8;

  // The counter must be able to hold DEBOUNCE-1. It is never narrower than 1 bit.
  function automatic int cabin_cnt_width(input int debounce);
    return (debounce < 1) ? 1 : $clog2(debounce + 1);
  endfunction

endpackage : cabin_cmd_pkg

`default_nettype wire

// File: rtl/cmd_debounce_ch.sv
// ============================================================================
// Module   : cmd_debounce_ch
// Brief    : Handles one command channel. It debounces the input, detects
//            edges and holds a pending rise while commands are blocked.
//            If CABIN_CMD_SYNC_EN is defined, a 2-FF input synchronizer is
//            added in front of the filter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmd_debounce_ch
  import cabin_cmd_pkg::*;
#(
  parameter int DEBOUNCE = CABIN_DEBOUNCE
) (
  input  logic clk,
  input  logic reset_n,
  input  logic allow_i,
  input  logic cmd_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic pending_o
);

  localparam int            CW      = cabin_cnt_width(DEBOUNCE);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

  logic s_in;

`ifdef CABIN_CMD_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[0], cmd_i};
  end

  assign s_in = sync_q[1];
`else
  assign s_in = cmd_i;
`endif

  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          pending_q, pending_d;
  logic          qual, qual_rise, qual_fall;

  always_comb begin
    qual      = (s_in != level_q) && (cnt_q == CNT_MAX);
    qual_rise = qual & s_in;
    qual_fall = qual & ~s_in;

    cnt_d   = ((s_in == level_q) || qual) ? '0 : cnt_q + 1'b1;
    level_d = qual ? s_in : level_q;

    // A fall always wins over a pending delivery.
    // This keeps rise and fall from pulsing together.
    rise_d = allow_i & ~qual_fall & (qual_rise | pending_q);
    fall_d = allow_i & qual_fall;

    pending_d = pending_q;
    if (qual_fall)                pending_d = 1'b0;
    else if (qual_rise & ~allow_i) pending_d = 1'b1;
    else if (allow_i)             pending_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      level_q   <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      pending_q <= pending_d;
    end
  end

  assign level_o   = level_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign pending_o = pending_q;

endmodule : cmd_debounce_ch

`default_nettype wire

// File: rtl/cabin_cmd_conditioner.sv
// ============================================================================
// Module   : cabin_cmd_conditioner
// Brief    : Conditions NUM_CH crew-panel commands. Each channel is debounced,
//            edge-detected and gated by allow_cmds. Defining
//            CABIN_CMD_SYNC_EN adds an input synchronizer on each channel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cabin_cmd_conditioner
  import cabin_cmd_pkg::*;
#(
  parameter int NUM_CH   = CABIN_NUM_CH,
  parameter int DEBOUNCE = CABIN_DEBOUNCE
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              allow_cmds,
  input  logic [NUM_CH-1:0] cmd_in,
  output logic [NUM_CH-1:0] cmd_level,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse,
  output logic [NUM_CH-1:0] pending
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    cmd_debounce_ch #(
      .DEBOUNCE (DEBOUNCE)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .allow_i   (allow_cmds),
      .cmd_i     (cmd_in[i]),
      .level_o   (cmd_level[i]),
      .rise_o    (rise_pulse[i]),
      .fall_o    (fall_pulse[i]),
      .pending_o (pending[i])
    );
  end

endmodule : cabin_cmd_conditioner

`default_nettype wire

// File: doc/cabin_cmd_conditioner.md
# cabin_cmd_conditioner

Multi-channel command conditioner for the cabin controller. Each of NUM_CH raw crew-panel command inputs is debounced, converted to a filtered level, and edge-detected into one-cycle rise/fall pulses. Pulses are gated by `allow_cmds`. Rising edges qualified while commands are blocked are held pending and delivered when commands are re-enabled. Sits between the panel input pins and the cabin state machines.

## Interface
- `NUM_CH`, default 4: number of command channels, ≥1.
- `DEBOUNCE`, default 8: consecutive cycles a changed input must hold before it is accepted, ≥1 (1 = no filtering).
- `clk` in 1: clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `allow_cmds` in 1: 1 = pulses may be issued.
- `cmd_in` in NUM_CH: raw command inputs; bit i = channel i.
- `cmd_level` out NUM_CH: debounced level per channel.
- `rise_pulse` out NUM_CH: one-cycle pulse on an accepted 0→1 transition, or on delivery of a pending rise.
- `fall_pulse` out NUM_CH: one-cycle pulse on an accepted 1→0 transition.
- `pending` out NUM_CH: a rise is held awaiting `allow_cmds`.

## Operation
- Per-channel state: `s_in` (sampled input), `cmd_level`, counter `cnt` (width `$clog2(DEBOUNCE+1)`), `pending`.
- **Debounce:**
  - If `s_in == cmd_level`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE-1`: `cmd_level <= s_in`, `cnt <= 0`, and a qualified edge is raised.
  - Else: `cnt <= cnt+1`.
  - A glitch shorter than DEBOUNCE cycles never changes `cmd_level`. Counting restarts from 0 on every mismatch break.
- **Qualified rise with `allow_cmds=1`:** `rise_pulse[i]=1` for one cycle.
- **Qualified rise with `allow_cmds=0`:** `pending[i] <= 1`; no pulse.
- **Qualified fall with `allow_cmds=1`:** `fall_pulse[i]=1`.
- **Qualified fall with `allow_cmds=0`:** no pulse; also clears `pending[i]`, which cancels the held rise.
- **Pending delivery:** `allow_cmds=1` with `pending[i]=1` → `rise_pulse[i]=1` once and `pending[i] <= 0`.
  - If a qualified rise coincides with delivery, exactly one pulse is issued.
- Debounce runs regardless of `allow_cmds`, so `cmd_level` always tracks the filtered input.
- Channels are fully independent; simultaneous events on different channels all pulse in the same cycle.
- `rise_pulse` and `fall_pulse` are never both high on one channel.

## Timing
- All outputs are registered.
- **Reset values:** `cmd_level=0`, `rise_pulse=0`, `fall_pulse=0`, `pending=0`, `cnt=0`.
- Reset mid-debounce discards any partial count.
- An input held high through reset yields `rise_pulse` DEBOUNCE cycles after reset release, if allowed.
- **Latency (without sync stage):** `cmd_in` first sampled high at edge k → `cmd_level=1` and `rise_pulse=1` after edge k+DEBOUNCE-1. Pulse and new level appear in the same cycle.
- **Pending delivery:** `allow_cmds` sampled 1 at edge m → `rise_pulse` high after edge m.
- The input-to-gate decision uses `allow_cmds` sampled on the same edge that updates `cmd_level`.

## Configuration
- Macro: `CABIN_CMD_SYNC_EN`.
- **Defined:** each `cmd_in` bit passes through a 2-FF synchronizer before `s_in`.
  - Synchronizer resets to 0.
  - Adds exactly 2 cycles to input-to-level latency.
- **Undefined:** `s_in = cmd_in` directly; inputs must already be synchronous to `clk`.
- `allow_cmds` is never synchronized by this block in either case.

## Structure
- Package `cabin_cmd_pkg`:
  - default constants `CABIN_NUM_CH=4`, `CABIN_DEBOUNCE=8`;
  - function computing the counter width.
- Sub-module `cmd_debounce_ch`:
  - one channel: synchronizer (under the macro), counter, level, edge/pending logic;
  - instantiated NUM_CH times in a generate loop;
  - the top only fans out `allow_cmds` and concatenates outputs.

## Test plan
- **Clean rise/fall:** DEBOUNCE=8, `allow_cmds=1`, `cmd_in[0]` 0→1 held 20 cycles, then 0 → `rise_pulse[0]` exactly 8 cycles after the rise, `fall_pulse[0]` 8 cycles after the fall, each 1 cycle wide.
- **Glitch reject:** `cmd_in[1]` high for 7 cycles, low 1 cycle, high 7 cycles → no pulse, `cmd_level[1]` stays 0.
- **Blocked then allowed:** `allow_cmds=0`, `cmd_in[2]` rises and is held → `pending[2]=1`, no pulse. `allow_cmds`→1 → single `rise_pulse[2]` the next cycle, `pending[2]` cleared.
- **Cancel:** `allow_cmds=0`, rise qualified, then fall qualified → `pending[2]` returns to 0. Re-allow → no pulse.
- **Simultaneous and reset:** all 4 channels rise on the same cycle → 4 pulses in the same cycle. Repeat with `reset_n=0` at count 5 → all outputs 0, no pulse until 8 full cycles after release.
- **`CABIN_CMD_SYNC_EN` defined:** clean rise → pulse at 10 cycles.
